// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: 50 MHz timing defaults, host-transmit state
// encoding, the host-to-device frame layout and common command codes.
package ps2_pkg;

  localparam int unsigned INHIBIT_CYCLES_DEF       = 6000;    // 120 us
  localparam int unsigned START_TIMEOUT_CYCLES_DEF = 750000;  // 15 ms
  localparam int unsigned XFER_TIMEOUT_CYCLES_DEF  = 100000;  // 2 ms

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned IDX_W   = 4;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_ABORT,
    ST_DONE
  } tx_state_e;

  // Bits after the start bit, in shift order from bit 0 upward.
  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
  } ps2_frame_t;

  function automatic ps2_frame_t make_frame(input logic [7:0] data);
    ps2_frame_t f;
    f.stop   = 1'b1;
    f.parity = ~^data;
    f.data   = data;
    return f;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake of the PS/2 host transmitter.
//   send/tx_data : request and byte from the requester
//   busy/done/ack_ok/timeout : transfer status back to the requester
interface ps2_host_tx_if;
  logic       send;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       timeout;

  modport master (output send, output tx_data,
                  input busy, input done, input ack_ok, input timeout);
  modport slave  (input send, input tx_data,
                  output busy, output done, output ack_ok, output timeout);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser plus falling-edge detect for one PS/2 line.
//   pin    : raw asynchronous line level
//   level  : synchronised level
//   fall_c : high for one cycle when the synchronised level goes 1 -> 0
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall_c
);

  logic meta_q, sync_q, prev_q;

  // Reset to the idle-high line level so release of reset is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level  = sync_q;
  assign fall_c = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, presents the start
// bit, shifts a byte + odd parity + stop on device clock falling edges,
// samples the device ACK and reports done / ack_ok / timeout.
//   clk, reset          : system clock, async active-low reset
//   host                : send/tx_data in, busy/done/ack_ok/timeout out
//   ps2_clock, ps2_data : raw open-collector line levels
//   ps2_clock_oe/_data_oe : 1 = pull the line low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES       = INHIBIT_CYCLES_DEF,
  parameter int unsigned START_TIMEOUT_CYCLES = START_TIMEOUT_CYCLES_DEF,
  parameter int unsigned XFER_TIMEOUT_CYCLES  = XFER_TIMEOUT_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  ps2_host_tx_if.slave  host,
  input  logic          ps2_clock,
  input  logic          ps2_data,
  output logic          ps2_clock_oe,
  output logic          ps2_data_oe
);

  localparam int unsigned CNT_W = $clog2(max3(INHIBIT_CYCLES, START_TIMEOUT_CYCLES,
                                              XFER_TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_PRE    =
    CNT_W'((INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_STOP   = IDX_W'(FRAME_W - 1);

  logic clk_lvl, clk_fall_c, data_lvl, data_fall_c;

  ps2_line_sync u_clk_sync (
    .clk, .reset, .pin(ps2_clock), .level(clk_lvl), .fall_c(clk_fall_c)
  );
  ps2_line_sync u_data_sync (
    .clk, .reset, .pin(ps2_data), .level(data_lvl), .fall_c(data_fall_c)
  );

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0] idx_q, idx_d;
  ps2_frame_t       frame_q, frame_d;
  logic             clk_oe_d, data_oe_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             ack_q, ack_d, to_q, to_d;

  // Saturating count; never wraps back into a valid window.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_q      <= '0;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ack_q        <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      ps2_clock_oe <= clk_oe_d;
      ps2_data_oe  <= data_oe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ack_q        <= ack_d;
      to_q         <= to_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    idx_d     = idx_q;
    frame_d   = frame_q;
    clk_oe_d  = 1'b0;
    data_oe_d = ps2_data_oe;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_d     = ack_q;
    to_d      = to_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (host.send) begin
          frame_d   = make_frame(host.tx_data);
          ack_d     = 1'b0;
          to_d      = 1'b0;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          data_oe_d = (INHIBIT_CYCLES < 2);
          state_d   = ST_INHIBIT;
        end
      end
      // Start bit goes out on the last inhibit cycle, one cycle ahead of
      // the clock release.
      ST_INHIBIT: begin
        clk_oe_d = 1'b1;
        if (cnt_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          cnt_d     = '0;
          idx_d     = '0;
          state_d   = ST_REQ;
        end else if (cnt_q == INH_PRE) begin
          data_oe_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (clk_fall_c) begin
          data_oe_d = ~frame_q[0];
          idx_d     = IDX_W'(1);
          cnt_d     = '0;
          state_d   = ST_SHIFT;
        end else if (cnt_q == START_LAST) begin
          data_oe_d = 1'b0;
          state_d   = ST_ABORT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == XFER_LAST) begin
          data_oe_d = 1'b0;
          state_d   = ST_ABORT;
        end else if (clk_fall_c) begin
          data_oe_d = ~frame_q[idx_q];
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == IDX_STOP) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (cnt_q == XFER_LAST) begin
          data_oe_d = 1'b0;
          state_d   = ST_ABORT;
        end else if (clk_fall_c) begin
          ack_d   = ~data_lvl;
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (cnt_q == XFER_LAST) begin
          data_oe_d = 1'b0;
          state_d   = ST_ABORT;
        end else if (clk_lvl && data_lvl) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_ABORT: begin
        data_oe_d = 1'b0;
        to_d      = 1'b1;
        ack_d     = 1'b0;
        done_d    = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  assign host.busy    = busy_q;
  assign host.done    = done_q;
  assign host.ack_ok  = ack_q;
  assign host.timeout = to_q;

  logic unused_data_fall;
  assign unused_data_fall = data_fall_c;

endmodule
